fnd_scan_controller: RTL
========================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter CLK_FREQ_HZ, default 100_000_000: clk frequency.
REQ-003 Parameter SCAN_HZ, default 1_000: digit-advance rate; TICK_DIV = CLK_FREQ_HZ/SCAN_HZ, integer, >= 2.
REQ-004 Parameter BLINK_HZ, default 2: blink rate; BLINK_DIV = CLK_FREQ_HZ/(2*BLINK_HZ), integer, >= 2.
REQ-005 Port clk, input, 1: the single clock; all logic in this domain.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port load_valid, input, 1: new display image offered.
REQ-008 Port load_ready, output, 1: no update pending; image accepted when load_valid && load_ready.
REQ-009 Port bcd_in, input, NUM_DIGITS*4: digit i at [4i+3:4i], digit 0 least significant.
REQ-010 Port dp_in, input, NUM_DIGITS: decimal point per digit, 1 = lit.
REQ-011 Port blink_en, input, NUM_DIGITS: per-digit blink enable.
REQ-012 Port lz_blank, input, 1: leading-zero blanking enable, sampled live.
REQ-013 Port brightness, input, 4: PWM duty, 0 = dark, 15 = full on, sampled live.
REQ-014 Port fnd_digit, output, NUM_DIGITS: active-low digit select, one-hot-low.
REQ-015 Port fnd_data, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-016 Port frame_done, output, 1: one-cycle pulse at each frame wrap.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and assert a one-cycle tick when at TICK_DIV-1.
REQ-018 Digit index SHALL increment on tick, wrapping from NUM_DIGITS-1 to 0; frame_done SHALL pulse in the cycle the index wraps.
REQ-019 Accepted image SHALL be stored in a shadow register; load_ready SHALL deassert the cycle after acceptance.
REQ-020 At each frame wrap with an update pending, shadow SHALL copy to active registers, load_ready SHALL reassert next cycle.
REQ-021 Image accepted in the same cycle as a wrap SHALL not apply at that wrap; applies at the following wrap.
REQ-022 Segment lookup: 0-9 standard patterns (0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 hex, dp bit high); 10-15 all segments off.
REQ-023 Bit 7 of fnd_data SHALL be 0 when active dp of the selected digit is 1, independently of digit value.
REQ-024 With lz_blank=1, digit i>0 SHALL blank (segments and dp off) when it and all higher digits are 0; digit 0 never lz-blanked.
REQ-025 Blink phase SHALL toggle every BLINK_DIV cycles; digit with active blink_en set SHALL blank while phase=1.
REQ-026 4-bit PWM counter SHALL increment every clk (wrap 15->0); digit drive enabled when brightness==15 or pwm_cnt < brightness.
REQ-027 When drive disabled or digit blanked, fnd_digit SHALL be all ones and fnd_data 8'hFF.
REQ-028 fnd_digit and fnd_data SHALL be registered, one cycle after digit index / PWM / blink state.

Reset
REQ-029 On reset low: fnd_digit all ones, fnd_data 8'hFF, frame_done 0, load_ready 1, digit index 0, tick/blink/PWM counters 0, blink phase 0, shadow and active registers 0, pending 0.
REQ-030 Reset asserted mid-frame or mid-update SHALL discard any pending image; no partial update appears after release.

Structure
REQ-031 Shared package fnd_pkg SHALL hold SEG_BLANK (8'hFF), the 16-entry segment table and the segment-lookup function.
REQ-032 Prescaler SHALL be sub-module fnd_tick_gen (parameter DIV, outputs one-cycle tick), instantiated for scan and blink.

Verification (NUM_DIGITS=4, CLK_FREQ_HZ=1000, SCAN_HZ=250 -> TICK_DIV=4, BLINK_HZ=50 -> BLINK_DIV=10)
REQ-033 Reset release, load 0x1234, brightness 15 -> after first wrap, digit0 F9? no: digit0 shows 4 (99), digit1 3 (B0), digit2 2 (A4), digit3 1 (F9), each for 4 cycles, frame_done every 16 cycles.
REQ-034 lz_blank=1, load 0x0050 -> digits 3,2 blanked (FF, digit all ones), digit1 shows 5 (92), digit0 shows 0 (C0).
REQ-035 Second load_valid while pending -> load_ready=0, image held; load in wrap cycle -> applied only at next wrap (16 cycles later).
REQ-036 brightness 4 -> digit drive active exactly 4 of every 16 cycles; brightness 0 -> fnd_digit constantly 1111.
REQ-037 blink_en=0001, dp_in=0100 -> digit0 blanked 10 cycles of every 20; digit2 fnd_data bit7=0.
REQ-038 Reset low while update pending -> all REQ-029 values within same cycle, load_ready=1, display stays blank until next accepted load.

Source files
------------

// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Shared constants and segment lookup for the FND scan display.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; index 15 first, codes 10..15 dark
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg_lookup(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : fnd_tick_gen
// Description : Free-running prescaler, one-cycle tick every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_controller
// Description : Multiplexed 7-segment scan driver with double-buffered image,
//               leading-zero blanking, per-digit blink and PWM brightness.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int BLINK_HZ    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS*4-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   fnd_digit,
  output logic [7:0]              fnd_data,
  output logic                    frame_done
);

  localparam int c_tick_div  = CLK_FREQ_HZ / SCAN_HZ;
  localparam int c_blink_div = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int c_idx_w     = $clog2(NUM_DIGITS);
  localparam logic [c_idx_w-1:0]    c_last_idx  = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_digit_one = NUM_DIGITS'(1);

  logic                    w_scan_tick;
  logic                    w_blink_tick;
  logic                    w_wrap;
  logic                    w_accept;
  logic                    w_drive;
  logic                    w_blank;
  logic                    w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_lz_vec;
  logic [3:0]              w_cur_bcd;
  logic [7:0]              w_cur_seg;

  logic [NUM_DIGITS*4-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [NUM_DIGITS-1:0]   r_shadow_blink;
  logic                    r_pending;
  logic [NUM_DIGITS*4-1:0] r_act_bcd;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blink;
  logic                    r_act_valid;
  logic [c_idx_w-1:0]      r_idx;
  logic                    r_frame_done;
  logic                    r_blink_phase;
  logic [3:0]              r_pwm_cnt;
  logic [NUM_DIGITS-1:0]   r_fnd_digit;
  logic [7:0]              r_fnd_data;

  fnd_tick_gen #(.DIV(c_tick_div)) u_scan_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_scan_tick)
  );

  fnd_tick_gen #(.DIV(c_blink_div)) u_blink_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_blink_tick)
  );

  assign w_wrap     = w_scan_tick && (r_idx == c_last_idx);
  assign w_accept   = load_valid && !r_pending;
  assign load_ready = !r_pending;
  assign frame_done = r_frame_done;
  assign fnd_digit  = r_fnd_digit;
  assign fnd_data   = r_fnd_data;

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    w_lz_vec     = '0;
    w_upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_upper_zero = w_upper_zero && (r_act_bcd[4*i +: 4] == 4'd0);
      w_lz_vec[i]  = w_upper_zero;
    end
  end

  assign w_cur_bcd = r_act_bcd[4*int'(r_idx) +: 4];
  assign w_cur_seg = seg_lookup(w_cur_bcd);
  assign w_drive   = (brightness == 4'hF) || (r_pwm_cnt < brightness);
  assign w_blank   = !r_act_valid
                   || (lz_blank && w_lz_vec[r_idx])
                   || (r_act_blink[r_idx] && r_blink_phase);

  // Image double buffer: the shadow only reaches the display at a frame wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow_bcd   <= '0;
      r_shadow_dp    <= '0;
      r_shadow_blink <= '0;
      r_pending      <= 1'b0;
      r_act_bcd      <= '0;
      r_act_dp       <= '0;
      r_act_blink    <= '0;
      r_act_valid    <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_act_bcd   <= r_shadow_bcd;
        r_act_dp    <= r_shadow_dp;
        r_act_blink <= r_shadow_blink;
        r_act_valid <= 1'b1;
        r_pending   <= 1'b0;
      end else if (w_accept) begin
        r_shadow_bcd   <= bcd_in;
        r_shadow_dp    <= dp_in;
        r_shadow_blink <= blink_en;
        r_pending      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_frame_done  <= 1'b0;
      r_blink_phase <= 1'b0;
      r_pwm_cnt     <= 4'd0;
    end else begin
      r_frame_done <= w_wrap;
      r_pwm_cnt    <= r_pwm_cnt + 4'd1;
      if (w_scan_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + c_idx_w'(1);
      end
      if (w_blink_tick) begin
        r_blink_phase <= !r_blink_phase;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fnd_digit <= '1;
      r_fnd_data  <= SEG_BLANK;
    end else if (w_drive && !w_blank) begin
      r_fnd_digit <= ~(c_digit_one << r_idx);
      r_fnd_data  <= {~r_act_dp[r_idx], w_cur_seg[6:0]};
    end else begin
      r_fnd_digit <= '1;
      r_fnd_data  <= SEG_BLANK;
    end
  end

endmodule
`default_nettype wire
